enc_scan_ctrl: RTL and testbench
================================

// Module: enc_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for N quadrature encoders sharing one Gray-code decode step.
//  Synchronises all A/B inputs and visits one channel per scan slot, round-robin.
//  Keeps a per-channel position counter and posts each detected step as a valid/ready event.
//  Sits between the raw encoder pins and the LED/UI logic in top, clocked by the PLL clk.
// PARAMETERS
//  N_ENC      4    number of encoder channels (2..16)
//  POS_WIDTH  8    position counter width per channel
//  SCAN_DIV   64   clocks per scan slot (>=3); full scan period = N_ENC*SCAN_DIV
// PORTS
//  clk         in   1              system clock (PLL output)
//  rst         in   1              asynchronous reset, active high
//  enc_a_raw   in   N_ENC          raw A inputs, asynchronous
//  enc_b_raw   in   N_ENC          raw B inputs, asynchronous
//  enable      in   1              scan enable
//  rd_sel      in   clog2(N_ENC)   channel for position readback
//  rd_pos      out  POS_WIDTH      position of rd_sel, registered
//  clr         in   1              one-cycle pulse: clear channel clr_sel
//  clr_sel     in   clog2(N_ENC)   channel to clear
//  evt_valid   out  1              step event pending
//  evt_ready   in   1              consumer accepts event
//  evt_chan    out  clog2(N_ENC)   channel of pending event
//  evt_dir     out  1              0 = +1 (up), 1 = -1 (down)
//  evt_overflow out 1              sticky: a step occurred while the event slot was full
//  err         out  N_ENC          sticky per channel: illegal double-bit transition seen
// BEHAVIOUR
//  Reset: pos[], last[], primed[], err, evt_*, evt_overflow, rd_pos, scan ptr, divider all 0; FSM in IDLE.
//  Sync: every A/B bit passes through a 3-flop chain. Decode uses stage 2. State = {A,B}.
//  FSM:
//   IDLE: stay while enable=0. Go to WAIT when enable=1.
//   WAIT: count SCAN_DIV-2 cycles.
//   SAMPLE: 1 cycle. Capture next={A,B} of channel ptr.
//   UPDATE: 1 cycle. Write pos/last/err and post the event.
//     ptr <= (ptr==N_ENC-1) ? 0 : ptr+1. Go to WAIT.
//  enable=0 in any state: FSM -> IDLE next cycle. An in-flight slot is dropped with no update.
//   ptr is held. primed[] is cleared to 0.
//  Decode at UPDATE, with L=last[ptr], X=next:
//   primed[ptr]=0: last<=X, primed<=1. No count, no err, no event.
//   X==L: no change.
//   Forward 00->01->11->10->00: pos+1, dir=0.
//   Reverse order: pos-1, dir=1.
//   Both bits changed: no count, err[ptr]<=1.
//   last[ptr]<=X in every case.
//  Position arithmetic is modulo 2^POS_WIDTH: 255+1=0, 0-1=255 at width 8.
//  Event: on a counted step, evt_chan/evt_dir are loaded and evt_valid<=1,
//   provided evt_valid==0 or (evt_valid&&evt_ready) in that cycle.
//   Otherwise the pending event is kept, evt_overflow<=1, and pos is still updated.
//  evt_valid&&evt_ready with no new step: evt_valid<=0 next cycle.
//  clr: pos[clr_sel]<=0 and err[clr_sel]<=0. evt_overflow<=0.
//   If it coincides with UPDATE of the same channel: pos ends at 0 and err ends at 0.
//   last is still updated and the event is still posted.
//  rd_pos <= pos[rd_sel] each cycle (1-cycle latency). It reflects writes from the prior cycle.
//  Step-rate limit: an encoder must hold each state >= N_ENC*SCAN_DIV+4 clocks to be counted.
// TESTING
//  1. rst, enable=1, ch0 00->01->11->10->00, each state held 300 clks, evt_ready=1
//     -> rd_pos(0)=4; 4 events chan=0 dir=0.
//  2. From reset, ch2 00->10 -> pos[2]=255 (wrap); one event chan=2 dir=1; err=0.
//  3. ch1 00->11 -> pos[1] unchanged, err=4'b0010, no event;
//     clr with clr_sel=1 -> err=0.
//  4. evt_ready=0; step up ch0, then step up ch3 -> evt_chan=0 held, evt_overflow=1,
//     pos[0]=1, pos[3]=1; evt_ready=1 for one cycle -> evt_valid=0 next cycle.
//  5. enable=0; move ch3 00->01->11; enable=1 -> after first scan: no count, no err, no event;
//     then 11->10 -> pos[3]+1.
//  6. clr with clr_sel=0 driven in the UPDATE cycle of a ch0 up-step -> pos[0]=0, event still posted;
//     asserting rst mid-WAIT clears all state asynchronously.

Source files
------------

// File: rtl/enc_scan_ctrl.sv
// enc_scan_ctrl
//   Round-robin scan controller for N_ENC quadrature encoders that share a
//   single Gray-code decode step. Each encoder gets one scan slot of SCAN_DIV
//   clocks. Within that slot the channel's synchronised {A,B} state is sampled
//   and then decoded against the last state seen for that channel.
//
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   enc_a_raw, enc_b_raw  raw asynchronous encoder pins, one bit per channel
//   enable                scan enable; dropping it aborts the current slot
//   rd_sel / rd_pos       registered position readback (1-cycle latency)
//   clr / clr_sel         one-cycle pulse that clears pos and err of a channel
//   evt_valid/evt_ready   single-entry step event handshake
//   evt_chan, evt_dir     channel and direction of the pending event (1 = down)
//   evt_overflow          sticky: a step was seen while the event slot was full
//   err                   sticky per channel: both bits changed in one step
module enc_scan_ctrl #(
  parameter int unsigned N_ENC     = 4,
  parameter int unsigned POS_WIDTH = 8,
  parameter int unsigned SCAN_DIV  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_ENC-1:0]           enc_a_raw,
  input  logic [N_ENC-1:0]           enc_b_raw,
  input  logic                       enable,
  input  logic [$clog2(N_ENC)-1:0]   rd_sel,
  output logic [POS_WIDTH-1:0]       rd_pos,
  input  logic                       clr,
  input  logic [$clog2(N_ENC)-1:0]   clr_sel,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(N_ENC)-1:0]   evt_chan,
  output logic                       evt_dir,
  output logic                       evt_overflow,
  output logic [N_ENC-1:0]           err
);

  localparam int unsigned SW = $clog2(N_ENC);
  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] LAST_CH  = SW'(N_ENC - 1);
  localparam logic [DW-1:0] WAIT_END = DW'(SCAN_DIV - 3);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Forward quadrature order: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] gray_fwd(input logic [1:0] s);
    case (s)
      2'b00:   gray_fwd = 2'b01;
      2'b01:   gray_fwd = 2'b11;
      2'b11:   gray_fwd = 2'b10;
      default: gray_fwd = 2'b00;
    endcase
  endfunction

  // 3-flop synchronisers; decode reads the last stage
  logic [N_ENC-1:0] r_a_s0, r_a_s1, r_a_s2;
  logic [N_ENC-1:0] r_b_s0, r_b_s1, r_b_s2;

  state_t                r_state;
  logic [DW-1:0]         r_div;
  logic [SW-1:0]         r_ptr;
  logic [1:0]            r_next;
  logic [POS_WIDTH-1:0]  r_pos [N_ENC];
  logic [1:0]            r_last [N_ENC];
  logic [N_ENC-1:0]      r_primed;
  logic [N_ENC-1:0]      r_err;
  logic                  r_evt_valid;
  logic [SW-1:0]         r_evt_chan;
  logic                  r_evt_dir;
  logic                  r_evt_ovf;
  logic [POS_WIDTH-1:0]  r_rd_pos;

  logic [1:0] w_last;
  logic       w_upd;
  logic       w_fwd;
  logic       w_rev;
  logic       w_step;
  logic       w_bad;

  always_comb begin
    w_last = r_last[r_ptr];
    // An UPDATE cycle with enable low is abandoned entirely
    w_upd  = (r_state == ST_UPDATE) && enable;
    w_fwd  = (gray_fwd(w_last) == r_next);
    w_rev  = (gray_fwd(r_next) == w_last);
    w_step = w_upd && r_primed[r_ptr] && (w_fwd || w_rev);
    w_bad  = w_upd && r_primed[r_ptr] && ((w_last ^ r_next) == 2'b11);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_s0 <= '0; r_a_s1 <= '0; r_a_s2 <= '0;
      r_b_s0 <= '0; r_b_s1 <= '0; r_b_s2 <= '0;
    end else begin
      r_a_s0 <= enc_a_raw; r_a_s1 <= r_a_s0; r_a_s2 <= r_a_s1;
      r_b_s0 <= enc_b_raw; r_b_s1 <= r_b_s0; r_b_s2 <= r_b_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_ptr       <= '0;
      r_next      <= '0;
      r_primed    <= '0;
      r_err       <= '0;
      r_evt_valid <= 1'b0;
      r_evt_chan  <= '0;
      r_evt_dir   <= 1'b0;
      r_evt_ovf   <= 1'b0;
      r_rd_pos    <= '0;
      for (int unsigned i = 0; i < N_ENC; i++) begin
        r_pos[i]  <= '0;
        r_last[i] <= '0;
      end
    end else begin
      if (!enable) begin
        // ptr is held so scanning resumes where it stopped; every channel
        // must be re-primed because the pins may have moved meanwhile
        r_state  <= ST_IDLE;
        r_div    <= '0;
        r_primed <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_WAIT;
            r_div   <= '0;
          end
          ST_WAIT: begin
            if (r_div == WAIT_END) begin
              r_state <= ST_SAMPLE;
              r_div   <= '0;
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
          ST_SAMPLE: begin
            r_next  <= {r_a_s2[r_ptr], r_b_s2[r_ptr]};
            r_state <= ST_UPDATE;
          end
          default: begin
            r_last[r_ptr]   <= r_next;
            r_primed[r_ptr] <= 1'b1;
            if (w_step)
              r_pos[r_ptr] <= w_fwd ? r_pos[r_ptr] + 1'b1 : r_pos[r_ptr] - 1'b1;
            if (w_bad)
              r_err[r_ptr] <= 1'b1;
            r_ptr   <= (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;
            r_state <= ST_WAIT;
          end
        endcase
      end

      // Single-entry event slot: a consumer handshake in the same cycle frees it
      if (w_step) begin
        if (!r_evt_valid || evt_ready) begin
          r_evt_valid <= 1'b1;
          r_evt_chan  <= r_ptr;
          r_evt_dir   <= !w_fwd;
        end else begin
          r_evt_ovf <= 1'b1;
        end
      end else if (r_evt_valid && evt_ready) begin
        r_evt_valid <= 1'b0;
      end

      // Placed last so a clear beats a same-cycle update of the same channel
      if (clr) begin
        r_pos[clr_sel] <= '0;
        r_err[clr_sel] <= 1'b0;
        r_evt_ovf      <= 1'b0;
      end

      r_rd_pos <= r_pos[rd_sel];
    end
  end

  assign rd_pos       = r_rd_pos;
  assign evt_valid    = r_evt_valid;
  assign evt_chan     = r_evt_chan;
  assign evt_dir      = r_evt_dir;
  assign evt_overflow = r_evt_ovf;
  assign err          = r_err;

endmodule

// File: tb/tb_enc_scan_ctrl.sv
module tb_enc_scan_ctrl;

  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int SD   = 64;
  localparam int HOLD = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  enc_a_raw = '0;
  logic [N-1:0]  enc_b_raw = '0;
  logic          enable = 1'b0;
  logic [1:0]    rd_sel = '0;
  logic [PW-1:0] rd_pos;
  logic          clr = 1'b0;
  logic [1:0]    clr_sel = '0;
  logic          evt_valid;
  logic          evt_ready = 1'b1;
  logic [1:0]    evt_chan;
  logic          evt_dir;
  logic          evt_overflow;
  logic [N-1:0]  err;

  enc_scan_ctrl #(.N_ENC(N), .POS_WIDTH(PW), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst),
    .enc_a_raw(enc_a_raw), .enc_b_raw(enc_b_raw),
    .enable(enable),
    .rd_sel(rd_sel), .rd_pos(rd_pos),
    .clr(clr), .clr_sel(clr_sel),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_chan(evt_chan), .evt_dir(evt_dir),
    .evt_overflow(evt_overflow), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Accepted-event log
  int         ev_cnt  = 0;
  int         ev_up   = 0;
  logic [1:0] ev_chan = '0;
  logic       ev_dir  = 1'b0;

  always @(posedge clk) begin
    if (evt_valid && evt_ready) begin
      ev_cnt  <= ev_cnt + 1;
      if (!evt_dir) ev_up <= ev_up + 1;
      ev_chan <= evt_chan;
      ev_dir  <= evt_dir;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [1:0] ab, input int hold);
    @(negedge clk);
    enc_a_raw[ch] = ab[1];
    enc_b_raw[ch] = ab[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic read_pos(input int ch, output logic [PW-1:0] v);
    @(negedge clk);
    rd_sel = 2'(ch);
    @(negedge clk);
    v = rd_pos;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] p;
    int e0, u0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_pos", 32'(rd_pos), 0);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ovf", 32'(evt_overflow), 0);
    rst = 1'b0;
    enable = 1'b1;

    // 1: four forward steps on ch0
    e0 = ev_cnt; u0 = ev_up;
    repeat (HOLD) @(negedge clk);
    set_ch(0, 2'b01, HOLD);
    set_ch(0, 2'b11, HOLD);
    set_ch(0, 2'b10, HOLD);
    set_ch(0, 2'b00, HOLD);
    read_pos(0, p);
    check("t1_pos0", 32'(p), 4);
    check("t1_events", 32'(ev_cnt - e0), 4);
    check("t1_up_events", 32'(ev_up - u0), 4);
    check("t1_chan", 32'(ev_chan), 0);

    // 2: reverse step from 0 wraps to 255
    pulse_rst();
    repeat (HOLD) @(negedge clk);
    e0 = ev_cnt;
    set_ch(2, 2'b10, HOLD);
    read_pos(2, p);
    check("t2_pos2_wrap", 32'(p), 255);
    check("t2_events", 32'(ev_cnt - e0), 1);
    check("t2_chan", 32'(ev_chan), 2);
    check("t2_dir", 32'(ev_dir), 1);
    check("t2_err", 32'(err), 0);

    // 3: double-bit transition on ch1, then clear it
    e0 = ev_cnt;
    set_ch(1, 2'b11, HOLD);
    check("t3_err", 32'(err), 32'b0010);
    read_pos(1, p);
    check("t3_pos1", 32'(p), 0);
    check("t3_no_event", 32'(ev_cnt - e0), 0);
    @(negedge clk);
    clr = 1'b1; clr_sel = 2'd1;
    @(negedge clk);
    clr = 1'b0;
    check("t3_err_clr", 32'(err), 0);

    // 4: event slot full -> overflow, pending event kept
    @(negedge clk);
    evt_ready = 1'b0;
    set_ch(0, 2'b01, HOLD);
    set_ch(3, 2'b01, HOLD);
    check("t4_valid", 32'(evt_valid), 1);
    check("t4_chan", 32'(evt_chan), 0);
    check("t4_dir", 32'(evt_dir), 0);
    check("t4_ovf", 32'(evt_overflow), 1);
    read_pos(0, p);
    check("t4_pos0", 32'(p), 1);
    read_pos(3, p);
    check("t4_pos3", 32'(p), 1);
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check("t4_valid_drop", 32'(evt_valid), 0);
    @(negedge clk);
    evt_ready = 1'b1;

    // 5: movement while disabled is absorbed by re-priming
    @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enc_a_raw[3] = 1'b1; enc_b_raw[3] = 1'b1;
    repeat (50) @(negedge clk);
    enable = 1'b1;
    e0 = ev_cnt;
    repeat (HOLD) @(negedge clk);
    read_pos(3, p);
    check("t5_pos3_held", 32'(p), 1);
    check("t5_err", 32'(err), 0);
    check("t5_no_event", 32'(ev_cnt - e0), 0);
    set_ch(3, 2'b10, HOLD);
    read_pos(3, p);
    check("t5_pos3_step", 32'(p), 2);
    check("t5_chan", 32'(ev_chan), 3);

    // 6: clr in the UPDATE cycle of a ch0 up-step.
    // After reset release with enable high, ch0 UPDATE sits between
    // posedges 64+256m and 65+256m; m=0 primes, m=1 counts 01->11.
    pulse_rst();
    e0 = ev_cnt;
    repeat (100) @(posedge clk);
    @(negedge clk);
    enc_a_raw[0] = 1'b1; enc_b_raw[0] = 1'b1;
    repeat (220) @(posedge clk);
    @(negedge clk);
    clr = 1'b1; clr_sel = 2'd0;
    @(negedge clk);
    clr = 1'b0;
    read_pos(0, p);
    check("t6_pos0_clr", 32'(p), 0);
    check("t6_events", 32'(ev_cnt - e0), 1);
    check("t6_chan", 32'(ev_chan), 0);
    check("t6_dir", 32'(ev_dir), 0);

    // Build non-zero state, then async reset between edges
    @(negedge clk);
    evt_ready = 1'b0;
    set_ch(0, 2'b10, HOLD);
    read_pos(0, p);
    check("t6_pos0_pre", 32'(p), 1);
    check("t6_valid_pre", 32'(evt_valid), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_rd_pos", 32'(rd_pos), 0);
    check("t6_async_valid", 32'(evt_valid), 0);
    check("t6_async_ovf", 32'(evt_overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    evt_ready = 1'b1;
    read_pos(0, p);
    check("t6_pos0_after_rst", 32'(p), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
